// File: rtl/spi_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : spi_deserializer
// Description : Oversampled SPI receiver; assembles MSB-first words and
//               hands them to a FIFO through a one-word holding register.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic                  frame_done,
    input  logic                  full,
    output logic                  write_en,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overrun,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int BC_WIDTH = $clog2(DATA_WIDTH + 1);
    localparam logic [BC_WIDTH-1:0] LAST_BIT = BC_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_q;
    logic [BC_WIDTH-1:0]   bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic                  hold_valid_q;
    logic                  frame_err_q;
    logic                  overrun_q;
    logic [CNT_WIDTH-1:0]  word_count_q;

    logic                  sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic                  mosi_s1_q, mosi_s2_q;
    logic [2:0]            fd_q;

    logic                  w_rise;
    logic                  w_done;
    logic                  w_fd;
    logic                  w_in_shift_after_rise;
    logic [DATA_WIDTH-1:0] w_shift_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            fd_q        <= '0;
        end else begin
            sclk_s1_q   <= sclk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            mosi_s1_q   <= mosi;
            mosi_s2_q   <= mosi_s1_q;
            fd_q        <= {fd_q[1:0], frame_done};
        end
    end

    assign w_rise    = sclk_s2_q & ~sclk_prev_q;
    assign w_done    = w_rise && (bit_cnt_q == LAST_BIT);
    assign w_fd      = fd_q[2];
    assign w_shift_d = {shift_q[DATA_WIDTH-2:0], mosi_s2_q};
    // State as it stands after this cycle's rise, so frame_done sees it second
    assign w_in_shift_after_rise = w_rise ? !w_done : (state_q == SHIFT);

    assign write_en   = hold_valid_q & ~full;
    assign write_data = hold_data_q;
    assign busy       = (state_q == SHIFT);
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign word_count = word_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            word_count_q <= '0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            if (write_en) begin
                hold_valid_q <= 1'b0;
                word_count_q <= word_count_q + 1'b1;
            end

            if (w_rise) begin
                shift_q <= w_shift_d;
                if (w_done) begin
                    bit_cnt_q <= '0;
                    state_q   <= IDLE;
                    // A word still waiting behind a full FIFO wins over the new one
                    if (hold_valid_q && !write_en) begin
                        overrun_q <= 1'b1;
                    end else begin
                        hold_data_q  <= w_shift_d;
                        hold_valid_q <= 1'b1;
                    end
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    state_q   <= SHIFT;
                end
            end

            if (w_fd && w_in_shift_after_rise) begin
                frame_err_q <= 1'b1;
                bit_cnt_q   <= '0;
                state_q     <= IDLE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_deserializer
// Description : Directed self-checking bench with a write-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       frame_done = 1'b0;
    logic       full = 1'b0;
    logic       write_en;
    logic [7:0] write_data;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic [3:0] word_count;

    int n_cmp = 0;
    int n_err = 0;
    int n_wr  = 0;
    int n_ovr = 0;
    int n_fe  = 0;
    logic [7:0] exp_q[$];

    spi_deserializer #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .mosi       (mosi),
        .frame_done (frame_done),
        .full       (full),
        .write_en   (write_en),
        .write_data (write_data),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (write_en) begin
                n_wr++;
                check("write_while_full", {31'd0, full}, 32'd0);
                if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
                else check("write_data", {24'd0, write_data}, {24'd0, exp_q.pop_front()});
            end
            if (overrun)   n_ovr++;
            if (frame_err) n_fe++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        tick(4);
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
        tick(8);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_write_en"},   {31'd0, write_en},   32'd0);
        check({tag, "_busy"},       {31'd0, busy},       32'd0);
        check({tag, "_frame_err"},  {31'd0, frame_err},  32'd0);
        check({tag, "_overrun"},    {31'd0, overrun},    32'd0);
        check({tag, "_write_data"}, {24'd0, write_data}, 32'd0);
        check({tag, "_word_count"}, {28'd0, word_count}, 32'd0);
    endtask

    initial begin
        logic [7:0] w;

        // Reset state
        tick(3);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        tick(4);

        // Single word, FIFO ready
        exp_q.push_back(8'hA5);
        send_word(8'hA5);
        check("a5_writes", n_wr, 1);
        check("a5_count", {28'd0, word_count}, 1);

        // Word held behind a full FIFO
        full = 1'b1;
        exp_q.push_back(8'h3C);
        send_word(8'h3C);
        tick(20);
        check("3c_held_no_write", n_wr, 1);
        check("3c_held_data", {24'd0, write_data}, 32'h3C);
        full = 1'b0;
        tick(4);
        check("3c_writes", n_wr, 2);
        check("3c_count", {28'd0, word_count}, 2);

        // Second word while the first is still held -> overrun
        full = 1'b1;
        exp_q.push_back(8'h11);
        send_word(8'h11);
        send_word(8'h22);
        check("overrun_pulses", n_ovr, 1);
        check("overrun_kept", {24'd0, write_data}, 32'h11);
        full = 1'b0;
        tick(4);
        check("overrun_writes", n_wr, 3);

        // Short frame
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        tick(2);
        check("short_busy", {31'd0, busy}, 1);
        frame_done = 1'b1;
        tick(1);
        frame_done = 1'b0;
        tick(8);
        check("short_frame_err", n_fe, 1);
        check("short_busy_drop", {31'd0, busy}, 0);
        check("short_no_write", n_wr, 3);
        exp_q.push_back(8'h96);
        send_word(8'h96);
        check("after_short_writes", n_wr, 4);
        check("no_extra_frame_err", n_fe, 1);

        // Reset mid-word
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        tick(2);
        check("midword_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        tick(3);
        @(negedge clk);
        check_idle_outputs("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        tick(4);
        exp_q.push_back(8'h5A);
        send_word(8'h5A);
        check("after_reset_writes", n_wr, 5);
        check("after_reset_count", {28'd0, word_count}, 1);

        // 16 more words wrap the 4-bit counter back to 1
        for (int i = 0; i < 16; i++) begin
            w = 8'($urandom_range(0, 255));
            exp_q.push_back(w);
            send_word(w);
        end
        check("wrap_count", {28'd0, word_count}, 1);
        check("wrap_writes", n_wr, 21);
        check("queue_drained", exp_q.size(), 0);
        check("total_overruns", n_ovr, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
